uart_bcd_rx: RTL and testbench



---
 rtl/uart_bcd_rx.sv | 198 +++++++++++++++++++
 tb/tb_uart_bcd_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_bcd_rx.sv
// Oversampling UART receiver that assembles ASCII digit pairs into two BCD digits.
// Optional 8E1 framing with parity check when UART_RX_PARITY_EN is defined.
module uart_bcd_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       bcd_valid
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q;
  logic                   do_sample;
  logic                   stop_chk;
  logic                   par_ok;
  logic                   digit_cnt;
  logic [3:0]             tens_q;
  logic                   is_digit;

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic do_par;
  assign par_ok = ~(^shift_q ^ par_q);
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_d     = bit_q;
    do_sample = 1'b0;
    stop_chk  = 1'b0;
`ifdef UART_RX_PARITY_EN
    do_par    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == MID) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d     = '0;
          do_sample = 1'b1;
          bit_d     = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          do_par  = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          stop_chk = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sync_q  <= '1;
      rx_prev <= 1'b1;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_in};
      rx_prev <= rx_s;
      if (do_sample) shift_q[bit_q] <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (do_par) par_q <= rx_s;
      parity_err <= stop_chk && !par_ok;
    end
  end
`endif

  // Frame result is registered; digit assembly then acts on the registered byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (stop_chk) begin
        if (!rx_s) begin
          frame_err <= 1'b1;
        end else if (par_ok) begin
          rx_data  <= shift_q;
          rx_valid <= 1'b1;
        end
      end
    end
  end

  assign is_digit = (rx_data[7:4] == 4'h3) && (rx_data[3:0] <= 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_cnt <= 1'b0;
      tens_q    <= '0;
      bcd1      <= '0;
      bcd0      <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (frame_err || parity_err) begin
`else
      if (frame_err) begin
`endif
        digit_cnt <= 1'b0;
      end else if (rx_valid) begin
        if (!is_digit) begin
          digit_cnt <= 1'b0;
        end else if (!digit_cnt) begin
          tens_q    <= rx_data[3:0];
          digit_cnt <= 1'b1;
        end else begin
          bcd1      <= tens_q;
          bcd0      <= rx_data[3:0];
          bcd_valid <= 1'b1;
          digit_cnt <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_bcd_rx.sv
// Directed bench for uart_bcd_rx: ASCII digit pairs, glitch, framing error, mid-frame reset.
module tb_uart_bcd_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       bcd_valid;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         pe_cnt = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rv_cnt = 0, fe_cnt = 0, bv_cnt = 0;
  logic [7:0] rd_last = 8'h00;
  logic [3:0] b1_last = 4'h0, b0_last = 4'h0;

  uart_bcd_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .bcd1      (bcd1),
    .bcd0      (bcd0),
    .bcd_valid (bcd_valid)
  );

  always #1 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin rv_cnt++; rd_last = rx_data; end
    if (frame_err) fe_cnt++;
    if (bcd_valid) begin bv_cnt++; b1_last = bcd1; b0_last = bcd0; end
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx_in = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(^b ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    bit_time(stop_bit);
    rx_in = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] abort_byte;
    abort_byte = 8'h55;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(4);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_bcd1", bcd1, 4'h0);
    check("reset_bcd0", bcd0, 4'h0);
    check("reset_bcd_valid", bcd_valid, 1'b0);

    // '0' then '6'
    send_byte(8'h30, 1'b1, 1'b0);
    idle(8);
    check("b0_rv_cnt", rv_cnt, 1);
    check("b0_rx_data", rd_last, 8'h30);
    check("b0_bv_cnt", bv_cnt, 0);
    send_byte(8'h36, 1'b1, 1'b0);
    idle(8);
    check("b1_rv_cnt", rv_cnt, 2);
    check("b1_rx_data", rd_last, 8'h36);
    check("p06_bv_cnt", bv_cnt, 1);
    check("p06_bcd1", b1_last, 4'h0);
    check("p06_bcd0", b0_last, 4'h6);

    // '1','9' back to back
    send_byte(8'h31, 1'b1, 1'b0);
    check("p19_mid_bcd1", bcd1, 4'h0);
    check("p19_mid_bcd0", bcd0, 4'h6);
    check("p19_mid_bv_cnt", bv_cnt, 1);
    send_byte(8'h39, 1'b1, 1'b0);
    idle(8);
    check("p19_rv_cnt", rv_cnt, 4);
    check("p19_bv_cnt", bv_cnt, 2);
    check("p19_bcd1", bcd1, 4'h1);
    check("p19_bcd0", bcd0, 4'h9);

    // 4-clock glitch on the line
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * CPB);
    check("glitch_rv_cnt", rv_cnt, 4);
    check("glitch_fe_cnt", fe_cnt, 0);
    send_byte(8'h35, 1'b1, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0);
    idle(8);
    check("p53_bv_cnt", bv_cnt, 3);
    check("p53_bcd1", bcd1, 4'h5);
    check("p53_bcd0", bcd0, 4'h3);

    // dangling '9', then bad stop bit must clear the pending digit
    send_byte(8'h39, 1'b1, 1'b0);
    send_byte(8'h37, 1'b0, 1'b0);
    idle(2 * CPB);
    check("ferr_fe_cnt", fe_cnt, 1);
    check("ferr_rv_cnt", rv_cnt, 7);
    check("ferr_rx_data", rx_data, 8'h39);
    send_byte(8'h34, 1'b1, 1'b0);
    send_byte(8'h32, 1'b1, 1'b0);
    idle(8);
    check("p42_bv_cnt", bv_cnt, 4);
    check("p42_bcd1", b1_last, 4'h4);
    check("p42_bcd0", b0_last, 4'h2);

    // '2','A','8','1'
    send_byte(8'h32, 1'b1, 1'b0);
    send_byte(8'h41, 1'b1, 1'b0);
    send_byte(8'h38, 1'b1, 1'b0);
    send_byte(8'h31, 1'b1, 1'b0);
    idle(8);
    check("p81_rv_cnt", rv_cnt, 13);
    check("p81_bv_cnt", bv_cnt, 5);
    check("p81_bcd1", b1_last, 4'h8);
    check("p81_bcd0", b0_last, 4'h1);

    // pending '9', then reset during bit 4 of a frame
    send_byte(8'h39, 1'b1, 1'b0);
    idle(8);
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(abort_byte[i]);
    rx_in = abort_byte[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    #0.5;
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_bcd1", bcd1, 4'h0);
    check("rst_bcd0", bcd0, 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(3 * CPB);
    check("rst_rv_cnt", rv_cnt, 14);
    check("rst_fe_cnt", fe_cnt, 1);
    check("rst_bv_cnt", bv_cnt, 5);
    send_byte(8'h30, 1'b1, 1'b0);
    send_byte(8'h37, 1'b1, 1'b0);
    idle(8);
    check("p07_bv_cnt", bv_cnt, 6);
    check("p07_bcd1", bcd1, 4'h0);
    check("p07_bcd0", bcd0, 4'h7);

`ifdef UART_RX_PARITY_EN
    send_byte(8'h31, 1'b1, 1'b1);
    idle(8);
    check("par_pe_cnt", pe_cnt, 1);
    check("par_rv_cnt", rv_cnt, 16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
